// File: rtl/canny_frame_ctrl_pkg.sv
// Shared frame geometry, counter widths and sequencer state type for the Canny frame controller.
// Latency: not applicable, declarations only.
// Backpressure: not applicable.
package canny_frame_ctrl_pkg;

    // Default frame geometry and datapath latency
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 512;
    localparam int BORDER = 4;
    localparam int LAT    = 16;

    // Position counter widths; they are sized for the default geometry and fix the port widths
    localparam int COL_W = 10;
    localparam int ROW_W = 9;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // One entry of the position delay line: qualifier plus pixel coordinates
    typedef struct packed {
        logic             vld;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } pos_t;

    localparam int POS_W = $bits(pos_t);

endpackage

// File: rtl/canny_pos_delay.sv
// Fixed-depth shift register that carries pixel position/qualifier alongside the datapath.
// Latency: DEPTH cycles from d_i to q_o.
// Backpressure: none; advances every cycle, independent of input stalls.
module canny_pos_delay #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift every cycle; reset empties the line so nothing stale reaches the window logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the Canny pipeline: numbers incoming pixels, tags results inside the cropped window, marks frame end.
// Latency: pix_* 1 cycle after in_*; win_valid LAT cycles after the matching pix_valid; frame_done 1 cycle after the last win_valid.
// Backpressure: none downstream; in_valid low stalls the position counters, in_valid in DRAIN/DONE is dropped.
module canny_frame_ctrl #(
    parameter int IMG_W  = canny_frame_ctrl_pkg::IMG_W,
    parameter int IMG_H  = canny_frame_ctrl_pkg::IMG_H,
    parameter int BORDER = canny_frame_ctrl_pkg::BORDER,
    parameter int LAT    = canny_frame_ctrl_pkg::LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic [9:0]  col,
    output logic [8:0]  row,
    output logic        lb_wr_en,
    output logic        win_valid,
    output logic        ready,
    output logic        frame_done
);
    import canny_frame_ctrl_pkg::*;

    // The win_valid register is the final delay stage, so the shared line is one shorter than LAT
    localparam int DLY_DEPTH = LAT - 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] WIN_C_LO = COL_W'(BORDER);
    localparam logic [COL_W-1:0] WIN_C_HI = COL_W'(IMG_W - BORDER - 1);
    localparam logic [ROW_W-1:0] WIN_R_LO = ROW_W'(BORDER);
    localparam logic [ROW_W-1:0] WIN_R_HI = ROW_W'(IMG_H - BORDER - 1);

    // Reset release synchroniser
    logic [1:0]       rst_sync_q;
    logic             run_en;

    // Sequencer state and position counters (position of the next pixel to accept)
    state_e           state_q;
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic             done_seen_q;

    // Registered pixel outputs
    logic [15:0]      pix_data_q;
    logic             pix_valid_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    // Window/frame-end outputs
    logic             win_valid_q;
    logic             win_last_q;
    logic             frame_done_q;
    logic             ready_q;

    logic             accept;
    logic             at_col_end;
    logic             at_last;
    logic             win_hit;
    logic             win_last;
    pos_t             dly_in;
    pos_t             dly_out;

    // Reset asserts asynchronously everywhere; the sequencer only starts once release has crossed two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run_en = rst_sync_q[1];

    // A pixel is taken when valid and the sequencer is waiting for or inside a frame
    assign accept     = in_valid && (((state_q == ST_IDLE) && run_en) || (state_q == ST_ACTIVE));
    assign at_col_end = (col_cnt_q == COL_LAST);
    assign at_last    = at_col_end && (row_cnt_q == ROW_LAST);

    // Next position: raster order, wrapping to (0,0) after the final pixel of the frame
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (accept) begin
            if (at_col_end) begin
                col_cnt_d = '0;
                row_cnt_d = at_last ? '0 : row_cnt_q + ROW_W'(1);
            end else begin
                col_cnt_d = col_cnt_q + COL_W'(1);
            end
        end
    end

    // Frame sequencer with registered pixel outputs; col/row hold their last value across stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            done_seen_q <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            pix_valid_q <= accept;
            if (accept) begin
                pix_data_q <= {in_data[7:0], in_data[15:8]};
                col_q      <= col_cnt_q;
                row_q      <= row_cnt_q;
            end

            // The last window result usually precedes the last input pixel, so remember it was seen
            if (state_q == ST_DONE) begin
                done_seen_q <= 1'b0;
            end else if (win_last_q) begin
                done_seen_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= at_last ? ST_DRAIN : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (accept && at_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave together with the frame_done pulse, or at once if it already went out
                    if (win_last_q || done_seen_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dly_in = '{vld: pix_valid_q, col: col_q, row: row_q};

    canny_pos_delay #(
        .DEPTH (DLY_DEPTH),
        .WIDTH (POS_W)
    ) u_pos_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dly_in),
        .q_o   (dly_out)
    );

    // Crop test on the delayed position, one cycle before the result it qualifies
    assign win_hit  = dly_out.vld
                   && (dly_out.col >= WIN_C_LO) && (dly_out.col <= WIN_C_HI)
                   && (dly_out.row >= WIN_R_LO) && (dly_out.row <= WIN_R_HI);
    assign win_last = win_hit && (dly_out.col == WIN_C_HI) && (dly_out.row == WIN_R_HI);

    // Window qualifier, frame-end pulse and output-phase flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            win_valid_q  <= win_hit;
            win_last_q   <= win_last;
            frame_done_q <= win_last_q;
            if (win_hit) begin
                ready_q <= 1'b1;
            end else if (frame_done_q) begin
                ready_q <= 1'b0;
            end
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign lb_wr_en   = pix_valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign win_valid  = win_valid_q;
    assign ready      = ready_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/canny_frame_ctrl.md
CANNY_FRAME_CTRL -- requirements
Module: canny_frame_ctrl

Interface
REQ-001 Parameter IMG_W, 640, input frame width in pixels.
REQ-002 Parameter IMG_H, 512, input frame height in lines.
REQ-003 Parameter BORDER, 4, pixels cropped from each edge of the output window.
REQ-004 Parameter LAT, 16, datapath latency in clock cycles from pix_valid to the corresponding result.
REQ-005 Port clk  input  1  single clock, rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port in_data  input  16  raw pixel, little-endian byte order.
REQ-008 Port in_valid  input  1  in_data qualifier; low means stall, no pixel this cycle.
REQ-009 Port pix_data  output  16  byte-swapped pixel to datapath, {in_data[7:0], in_data[15:8]}.
REQ-010 Port pix_valid  output  1  pixel accepted this cycle.
REQ-011 Port col  output  10  column of the current pixel.
REQ-012 Port row  output  9  line of the current pixel.
REQ-013 Port lb_wr_en  output  1  line-buffer write enable, equal to pix_valid.
REQ-014 Port win_valid  output  1  datapath result at this cycle lies inside the cropped window.
REQ-015 Port ready  output  1  output phase active.
REQ-016 Port frame_done  output  1  one-cycle pulse after the last windowed result.

Function
REQ-017 FSM states IDLE, ACTIVE, DRAIN, DONE; encoding is free.
REQ-018 IDLE -> ACTIVE on the first in_valid, which is pixel (row 0, col 0).
REQ-019 In ACTIVE, pix_data, pix_valid, col and row are registered with 1-cycle latency from in_data/in_valid.
REQ-020 col increments per accepted pixel and wraps IMG_W-1 -> 0 with row increment.
REQ-021 col and row hold when in_valid=0 (stall); no pixel is dropped or duplicated.
REQ-022 ACTIVE -> DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-023 In DRAIN, in_valid is ignored and pix_valid=0.
REQ-024 A LAT-deep shift register carries {valid, col, row}, advancing every cycle regardless of stall.
REQ-025 win_valid = delayed valid AND BORDER <= dcol <= IMG_W-BORDER-1 AND BORDER <= drow <= IMG_H-BORDER-1; with defaults this is 632x504 = 318528 results per frame.
REQ-026 ready rises with the first win_valid of a frame and falls the cycle after frame_done.
REQ-027 frame_done pulses for one cycle, in the cycle after the last win_valid (delayed position (IMG_H-BORDER-1, IMG_W-BORDER-1)).
REQ-028 DRAIN -> DONE with frame_done; DONE -> IDLE on the next cycle; a new frame may start from IDLE.
REQ-029 in_valid in DONE is ignored; the first in_valid seen in IDLE starts the next frame.
REQ-030 Comparisons use unsigned arithmetic at counter width; no overflow is possible within IMG_W and IMG_H.

Reset
REQ-031 rst_n low asynchronously clears the FSM to IDLE, counters to 0, the delay line to invalid, and every output to 0.
REQ-032 Reset mid-frame aborts the frame; no frame_done is issued and the next frame restarts at (0,0).
REQ-033 Release of rst_n is synchronised to clk before the FSM leaves IDLE.

Structure
REQ-034 A shared package holds IMG_W, IMG_H, BORDER, LAT, the counter widths and the FSM state typedef.
REQ-035 The delay line is a sub-module, canny_pos_delay, parameterised by depth and width.

Verification
REQ-036 640x512 continuous in_valid -> 327680 pix_valid, 318528 win_valid, one frame_done, final state IDLE.
REQ-037 in_data=16'h1234 -> pix_data=16'h3412 one cycle later.
REQ-038 in_valid low for 5 cycles at (row 3, col 639) -> counters hold, next pixel is (4,0), totals unchanged.
REQ-039 First win_valid occurs LAT cycles after the pixel at (4,4) is accepted, and ready rises in the same cycle.
REQ-040 rst_n pulsed low at row 100 -> outputs 0 immediately, no frame_done; the next frame completes with full counts.
REQ-041 Two back-to-back frames -> two frame_done pulses, 637056 win_valid in total.
